// File: rtl/io_bank_pkg.sv
// Shared definitions for the io_bank peripheral: register offsets, STATUS bit
// positions, the CPU-side window base and the register decoder.
// Imported by io_bank and by anything that needs to address its registers.
package io_bank_pkg;

  // CPU address of byte offset 0 of the bank.
  localparam logic [31:0] IO_BASE = 32'h8000_0000;

  // Byte offsets within the window; only bits [7:2] take part in decode.
  localparam logic [7:0] IO_GPIO_OUT  = 8'h00;
  localparam logic [7:0] IO_GPIO_IN   = 8'h04;
  localparam logic [7:0] IO_TIMER     = 8'h08;
  localparam logic [7:0] IO_TIMER_CMP = 8'h0C;
  localparam logic [7:0] IO_STATUS    = 8'h10;
  localparam logic [7:0] IO_TX_DATA   = 8'h14;
  localparam logic [7:0] IO_RX_DATA   = 8'h18;

  // STATUS bit positions.
  localparam int ST_TX_FULL     = 0;
  localparam int ST_TX_EMPTY    = 1;
  localparam int ST_TIMER_MATCH = 2;
  localparam int ST_RX_FULL     = 3;
  localparam int ST_TX_OVF      = 4;

  typedef enum logic [2:0] {
    REG_GPIO_OUT,
    REG_GPIO_IN,
    REG_TIMER,
    REG_TIMER_CMP,
    REG_STATUS,
    REG_TX_DATA,
    REG_RX_DATA,
    REG_NONE
  } reg_sel_e;

  // Word decode; the byte-within-word bits are ignored.
  function automatic reg_sel_e decode_reg(input logic [7:0] addr);
    reg_sel_e sel;
    case (addr[7:2])
      IO_GPIO_OUT[7:2]:  sel = REG_GPIO_OUT;
      IO_GPIO_IN[7:2]:   sel = REG_GPIO_IN;
      IO_TIMER[7:2]:     sel = REG_TIMER;
      IO_TIMER_CMP[7:2]: sel = REG_TIMER_CMP;
      IO_STATUS[7:2]:    sel = REG_STATUS;
      IO_TX_DATA[7:2]:   sel = REG_TX_DATA;
      IO_RX_DATA[7:2]:   sel = REG_RX_DATA;
      default:           sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/io_bank_if.sv
// CPU-side access bus of the I/O bank (address, enable, direction, data).
// master: the MMU I/O port driving accesses; slave: the bank answering them.
// Read data is combinational from the slave in the same cycle as the access.
interface io_bank_if;
  logic [7:0]  io_addr;
  logic        io_en;
  logic        io_we;
  logic [31:0] io_data_write;
  logic [31:0] io_data_read;

  modport master (
    output io_addr, io_en, io_we, io_data_write,
    input  io_data_read
  );

  modport slave (
    input  io_addr, io_en, io_we, io_data_write,
    output io_data_read
  );
endinterface

// File: rtl/io_fifo.sv
// Parameterised synchronous FIFO: push/pop, full/empty/count, head word visible.
// Ports: clk, reset (async active-high), push/push_dat, pop, head_dat, full, empty, count.
// A push while full is taken only when a pop happens in the same cycle.
module io_fifo #(
  parameter int W         = 8,
  parameter int DEPTH     = 4,
  parameter int DEPTH_LOG = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     push_dat,
  input  logic             pop,
  output logic [W-1:0]     head_dat,
  output logic             full,
  output logic             empty,
  output logic [DEPTH_LOG:0] count
);

  localparam int CNT_W = DEPTH_LOG + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [W-1:0]         mem_q [DEPTH];
  logic [W-1:0]         mem_d [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 do_push, do_pop;

  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  // Drive zero rather than a stale entry when nothing is queued.
  assign head_dat = empty ? '0 : mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + DEPTH_LOG'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + DEPTH_LOG'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/io_bank.sv
// Memory-mapped I/O bank: GPIO out/in, free-running timer with sticky compare
// interrupt, byte TX FIFO onto a valid/ready stream, one-entry RX holding register.
// Ports: clk, reset (async active-high), io (bus slave), gpio_out/gpio_in,
// irq_timer, tx_data/tx_valid/tx_ready, rx_data/rx_valid/rx_ready.
module io_bank
  import io_bank_pkg::*;
#(
  parameter int GPIO_W       = 8,
  parameter int TX_DEPTH     = 4,
  parameter int TX_DEPTH_LOG = 2
) (
  input  logic              clk,
  input  logic              reset,
  io_bank_if.slave          io,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic              irq_timer,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);

  reg_sel_e sel;
  logic     wr_en, rd_en;

  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] gpio_s1_q, gpio_s1_d;
  logic [GPIO_W-1:0] gpio_s2_q, gpio_s2_d;
  logic [31:0]       timer_q, timer_d;
  logic [31:0]       cmp_q, cmp_d;
  logic              match_q, match_d;
  logic              ovf_q, ovf_d;
  logic              rx_full_q, rx_full_d;
  logic [7:0]        rx_byte_q, rx_byte_d;

  logic              tx_push_req, tx_push, tx_pop;
  logic              tx_full, tx_empty;
  logic [7:0]        tx_head;
  logic [TX_DEPTH_LOG:0] tx_cnt_unused;
  logic              status_wr, rx_cap, rx_clr;

  assign sel   = decode_reg(io.io_addr);
  assign wr_en = io.io_en & io.io_we;
  assign rd_en = io.io_en & ~io.io_we;

  assign status_wr   = wr_en && (sel == REG_STATUS);
  assign tx_push_req = wr_en && (sel == REG_TX_DATA);
  assign tx_pop      = tx_valid & tx_ready;
  // A write to a full FIFO still lands if the head leaves in the same cycle.
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);

  // No bypass: a byte can only be captured while the holding register is empty.
  assign rx_cap = rx_valid & ~rx_full_q;
  assign rx_clr = rd_en && (sel == REG_RX_DATA) && rx_full_q;

  io_fifo #(
    .W         (8),
    .DEPTH     (TX_DEPTH),
    .DEPTH_LOG (TX_DEPTH_LOG)
  ) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (tx_push),
    .push_dat (io.io_data_write[7:0]),
    .pop      (tx_pop),
    .head_dat (tx_head),
    .full     (tx_full),
    .empty    (tx_empty),
    .count    (tx_cnt_unused)
  );

  always_comb begin
    gpio_out_d = gpio_out_q;
    if (wr_en && (sel == REG_GPIO_OUT)) gpio_out_d = io.io_data_write[GPIO_W-1:0];

    gpio_s1_d = gpio_in;
    gpio_s2_d = gpio_s1_q;

    // Writing TIMER overrides the increment for that cycle.
    timer_d = (wr_en && (sel == REG_TIMER)) ? 32'd0 : timer_q + 32'd1;

    cmp_d = cmp_q;
    if (wr_en && (sel == REG_TIMER_CMP)) cmp_d = io.io_data_write;

    // Sticky flags: a new event outranks a same-cycle write-1-to-clear.
    match_d = (timer_q == cmp_q) |
              (match_q & ~(status_wr & io.io_data_write[ST_TIMER_MATCH]));
    ovf_d   = (tx_push_req & tx_full & ~tx_pop) |
              (ovf_q & ~(status_wr & io.io_data_write[ST_TX_OVF]));

    rx_full_d = rx_full_q;
    rx_byte_d = rx_byte_q;
    if (rx_cap) begin
      rx_full_d = 1'b1;
      rx_byte_d = rx_data;
    end else if (rx_clr) begin
      rx_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_out_q <= '0;
      gpio_s1_q  <= '0;
      gpio_s2_q  <= '0;
      timer_q    <= '0;
      cmp_q      <= 32'hFFFF_FFFF;
      match_q    <= 1'b0;
      ovf_q      <= 1'b0;
      rx_full_q  <= 1'b0;
      rx_byte_q  <= '0;
    end else begin
      gpio_out_q <= gpio_out_d;
      gpio_s1_q  <= gpio_s1_d;
      gpio_s2_q  <= gpio_s2_d;
      timer_q    <= timer_d;
      cmp_q      <= cmp_d;
      match_q    <= match_d;
      ovf_q      <= ovf_d;
      rx_full_q  <= rx_full_d;
      rx_byte_q  <= rx_byte_d;
    end
  end

  // Combinational read-back; zero for writes, idle cycles, WO and unmapped.
  always_comb begin
    io.io_data_read = '0;
    if (rd_en) begin
      case (sel)
        REG_GPIO_OUT:  io.io_data_read = {{(32-GPIO_W){1'b0}}, gpio_out_q};
        REG_GPIO_IN:   io.io_data_read = {{(32-GPIO_W){1'b0}}, gpio_s2_q};
        REG_TIMER:     io.io_data_read = timer_q;
        REG_TIMER_CMP: io.io_data_read = cmp_q;
        REG_STATUS: begin
          io.io_data_read[ST_TX_FULL]     = tx_full;
          io.io_data_read[ST_TX_EMPTY]    = tx_empty;
          io.io_data_read[ST_TIMER_MATCH] = match_q;
          io.io_data_read[ST_RX_FULL]     = rx_full_q;
          io.io_data_read[ST_TX_OVF]      = ovf_q;
        end
        REG_RX_DATA:   io.io_data_read = {24'd0, rx_full_q ? rx_byte_q : 8'd0};
        default:       io.io_data_read = '0;
      endcase
    end
  end

  assign gpio_out  = gpio_out_q;
  assign irq_timer = match_q;
  assign tx_valid  = ~tx_empty;
  assign tx_data   = tx_head;
  assign rx_ready  = ~rx_full_q;

endmodule
